uart_frame_parser: RTL

Byte-stream framer directly downstream of the UART receiver. It consumes each received byte and its single-cycle ready strobe, then extracts framed command packets of the form SYNC, CMD, LEN, PAYLOAD[LEN], CHK. It outputs a validated command with its packed payload to the coprocessor logic and flags malformed or stalled frames.

---
 rtl/uart_frame_parser.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/uart_frame_parser.sv
// uart_frame_parser: extracts SYNC/CMD/LEN/PAYLOAD/CHK command frames from the
// UART receive byte stream. It presents each good frame with a one-cycle
// frame_valid pulse and flags checksum, length and inter-byte timeout errors.
module uart_frame_parser #(
  parameter int               DBITS       = 8,
  parameter int               MAX_PAYLOAD = 4,
  parameter logic [DBITS-1:0] SYNC_BYTE   = 8'hA5,
  parameter int               TO_LIMIT    = 100000,
  parameter int               TO_BITS     = 17
) (
  input  logic                         clk_100MHz,
  input  logic                         reset,
  input  logic [DBITS-1:0]             rx_data,
  input  logic                         rx_valid,
  output logic                         frame_valid,
  output logic [DBITS-1:0]             frame_cmd,
  output logic [DBITS-1:0]             frame_len,
  output logic [DBITS*MAX_PAYLOAD-1:0] frame_payload,
  output logic                         chk_err,
  output logic                         len_err,
  output logic                         timeout_err,
  output logic                         busy
);

  localparam int                 IDX_W   = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1;
  localparam logic [DBITS-1:0]   MAX_LEN = DBITS'(MAX_PAYLOAD);
  localparam logic [DBITS-1:0]   ONE_LEN = DBITS'(1);
  localparam logic [IDX_W-1:0]   ONE_IDX = IDX_W'(1);
  localparam logic [TO_BITS-1:0] TO_LAST = TO_BITS'(TO_LIMIT - 1);
  localparam logic [TO_BITS-1:0] ONE_TO  = TO_BITS'(1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CMD     = 3'd1,
    S_LEN     = 3'd2,
    S_PAYLOAD = 3'd3,
    S_CHK     = 3'd4
  } state_t;

  // Running checksum step: the frame checksum is the XOR of CMD, LEN and payload.
  function automatic logic [DBITS-1:0] xor_acc(input logic [DBITS-1:0] acc,
                                               input logic [DBITS-1:0] data);
    return acc ^ data;
  endfunction

  state_t                           state_r, state_next_s;
  logic [DBITS-1:0]                 cmd_r, len_r, xor_r;
  logic [IDX_W-1:0]                 idx_r;
  logic [MAX_PAYLOAD-1:0][DBITS-1:0] buf_r;
  logic [TO_BITS-1:0]               to_cnt_r;

  logic to_hit_s, last_slot_s, sync_s;
  logic frame_valid_s, chk_err_s, len_err_s, timeout_err_s;

  logic                         frame_valid_r, chk_err_r, len_err_r, timeout_err_r, busy_r;
  logic [DBITS-1:0]             frame_cmd_r, frame_len_r;
  logic [DBITS*MAX_PAYLOAD-1:0] frame_payload_r;

  // The timeout only fires in cycles without a byte; a coinciding byte is handled by the rx_valid branches.
  assign to_hit_s    = (state_r != S_IDLE) && (to_cnt_r == TO_LAST);
  assign last_slot_s = (DBITS'(idx_r) == (len_r - ONE_LEN));
  assign sync_s      = (rx_data == SYNC_BYTE);

  // State register.
  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic: one transition per received byte, or abort to IDLE on timeout.
  always_comb begin
    state_next_s = state_r;
    if (rx_valid) begin
      case (state_r)
        S_IDLE: begin
          if (sync_s) state_next_s = S_CMD;
          else        state_next_s = S_IDLE;
        end
        S_CMD: state_next_s = S_LEN;
        S_LEN: begin
          if (rx_data > MAX_LEN)     state_next_s = S_IDLE;
          else if (rx_data == '0)    state_next_s = S_CHK;
          else                       state_next_s = S_PAYLOAD;
        end
        S_PAYLOAD: begin
          if (last_slot_s) state_next_s = S_CHK;
          else             state_next_s = S_PAYLOAD;
        end
        S_CHK:   state_next_s = S_IDLE;
        default: state_next_s = S_IDLE;
      endcase
    end else if (to_hit_s) begin
      state_next_s = S_IDLE;
    end else begin
      state_next_s = state_r;
    end
  end

  // Output decode: at most one of the result pulses is raised per cycle.
  always_comb begin
    frame_valid_s = 1'b0;
    chk_err_s     = 1'b0;
    len_err_s     = 1'b0;
    timeout_err_s = 1'b0;
    if (rx_valid) begin
      case (state_r)
        S_LEN: len_err_s = (rx_data > MAX_LEN);
        S_CHK: begin
          if (rx_data == xor_r) frame_valid_s = 1'b1;
          else                  chk_err_s     = 1'b1;
        end
        default: frame_valid_s = 1'b0;
      endcase
    end else begin
      timeout_err_s = to_hit_s;
    end
  end

  // Frame datapath: command, length, slot index, running XOR and payload buffer.
  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      cmd_r <= '0;
      len_r <= '0;
      xor_r <= '0;
      idx_r <= '0;
      buf_r <= '0;
    end else if (rx_valid) begin
      case (state_r)
        S_IDLE: begin
          if (sync_s) begin
            buf_r <= '0;
            idx_r <= '0;
            xor_r <= '0;
          end
        end
        S_CMD: begin
          cmd_r <= rx_data;
          xor_r <= rx_data;
        end
        S_LEN: begin
          len_r <= rx_data;
          xor_r <= xor_acc(xor_r, rx_data);
          idx_r <= '0;
        end
        S_PAYLOAD: begin
          buf_r[idx_r] <= rx_data;
          xor_r        <= xor_acc(xor_r, rx_data);
          idx_r        <= idx_r + ONE_IDX;
        end
        default: cmd_r <= cmd_r;
      endcase
    end
  end

  // Inter-byte timeout counter: runs only mid-frame and restarts on every byte.
  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      to_cnt_r <= '0;
    end else if (rx_valid || (state_r == S_IDLE) || to_hit_s) begin
      to_cnt_r <= '0;
    end else begin
      to_cnt_r <= to_cnt_r + ONE_TO;
    end
  end

  // Registered outputs; frame_* update only on a good frame and hold otherwise.
  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      frame_valid_r   <= 1'b0;
      chk_err_r       <= 1'b0;
      len_err_r       <= 1'b0;
      timeout_err_r   <= 1'b0;
      busy_r          <= 1'b0;
      frame_cmd_r     <= '0;
      frame_len_r     <= '0;
      frame_payload_r <= '0;
    end else begin
      frame_valid_r <= frame_valid_s;
      chk_err_r     <= chk_err_s;
      len_err_r     <= len_err_s;
      timeout_err_r <= timeout_err_s;
      busy_r        <= (state_next_s != S_IDLE);
      if (frame_valid_s) begin
        frame_cmd_r     <= cmd_r;
        frame_len_r     <= len_r;
        frame_payload_r <= buf_r;
      end
    end
  end

  assign frame_valid   = frame_valid_r;
  assign chk_err       = chk_err_r;
  assign len_err       = len_err_r;
  assign timeout_err   = timeout_err_r;
  assign busy          = busy_r;
  assign frame_cmd     = frame_cmd_r;
  assign frame_len     = frame_len_r;
  assign frame_payload = frame_payload_r;

endmodule
